mips_wb_writeback: RTL
======================

// Module: mips_wb_writeback
// PURPOSE
// - Writeback stage: accepts retiring instructions from MEM/WB, waits for the load response if needed, and drives the regfile write port (wb_dest_en/idx/dat).
// - Aligns and extends load data, suppresses writes to r0, and back-pressures MEM while a load is outstanding.
// - Sits between the MEM stage/data-memory response path and mips_id_regfile.
// PARAMETERS
// - DW  32  data width (= `MIPS_DATA_WIDTH)
// - AW  5   register index width (= `MIPS_RFIDX_WIDTH)
// PORTS
// - clk             in   1   core clock; all state on rising edge
// - rst_n           in   1   async active-low reset
// - mem_valid       in   1   MEM stage presents a retiring instruction
// - mem_ready       out  1   stage can accept; transfer = mem_valid & mem_ready
// - mem_dest_en     in   1   instruction writes a register
// - mem_dest_idx    in   AW  destination register index
// - mem_alu_dat     in   DW  non-load result (ALU / link value)
// - mem_is_load     in   1   result comes from data memory
// - mem_ld_size     in   2   00 byte, 01 half, 10 word, 11 treated as word
// - mem_ld_signed   in   1   1 = sign-extend, 0 = zero-extend (byte/half only)
// - mem_addr_lo     in   2   load address bits [1:0]
// - dmem_rsp_valid  in   1   load data valid (single-cycle pulse)
// - dmem_rsp_dat    in   DW  raw aligned word from data memory
// - wb_dest_en      out  1   regfile write enable (registered)
// - wb_dest_idx     out  AW  regfile write index (registered)
// - wb_dest_dat     out  DW  regfile write data (registered)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; wb_dest_en=0, wb_dest_idx=0, wb_dest_dat=0; captured fields cleared; mem_ready=1 after deassertion.
// - FSM IDLE: mem_ready=1. On transfer, capture all mem_* fields.
//   - Non-load transfer in cycle N: wb_dest_en=1 in N+1 only, with idx=captured idx and dat=alu_dat; stay IDLE. Back-to-back non-loads give 1 write/cycle.
//   - Load transfer: go to WAIT_LD; wb_dest_en=0 next cycle.
// - FSM WAIT_LD: mem_ready=0 (combinational from state). On dmem_rsp_valid in cycle M, register the formatted data; wb_dest_en=1 in M+1; state=IDLE in M+1 (mem_ready=1 in M+1).
// - dmem_rsp_valid while IDLE is ignored: no write, no state change. The response never arrives in the accept cycle.
// - Write qualification: wb_dest_en = captured dest_en & (idx != 0). An r0 destination still walks the FSM, but no write is issued and wb_dest_en stays 0.
// - wb_dest_en is a 1-cycle pulse. idx/dat hold their last values while en=0.
// - Load format (big-endian):
//   - byte lane = dmem_rsp_dat[31-8*addr_lo -: 8]
//   - half = addr_lo[1] ? [15:0] : [31:16]; addr_lo[0] is ignored for half
//   - word ignores addr_lo
//   - extend to DW per mem_ld_signed
// - Reset mid-WAIT_LD: return to IDLE, no write. A late response is dropped per the IDLE rule.
// - Pure pass-through arithmetic; no width growth. All outputs are registered; no combinational path from mem_* to wb_*.
// STRUCTURE
// - Shared package/defines: `MIPS_LDSZ_B/H/W encodings, WB state encodings (IDLE=1'b0, WAIT_LD=1'b1), `MIPS_DATA_WIDTH, `MIPS_RFIDX_WIDTH.
// - Sub-module mips_wb_ldfmt: combinational lane select + sign/zero extend (size, signed, addr_lo, raw) -> DW.
// - Top: capture register, 2-state FSM, output register.
// TESTING
// - Reset: hold rst_n=0 with mem_valid=1 -> wb_dest_en=0, idx=0, dat=0; mem_ready=1 after release.
// - ALU stream: 3 back-to-back non-loads to r5/r6/r7 with 0x11/0x22/0x33 -> en=1 on 3 consecutive cycles, each lagging its accept by 1.
// - Load byte signed: addr_lo=2'b01, rsp=0x12F45678 after 3-cycle wait -> mem_ready=0 during the wait; write 0xFFFFFFF4 one cycle after rsp.
// - Load half unsigned: addr_lo=2'b10, rsp=0x1234ABCD -> 0x0000ABCD. Word load with addr_lo=3 -> raw word.
// - r0 suppression: non-load to r0, dat=0xDEADBEEF -> wb_dest_en never rises; the next instruction to r1 writes normally.
// - Reset mid-load: assert rst_n=0 in WAIT_LD, release, then pulse dmem_rsp_valid -> no write, state IDLE, mem_ready=1.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared widths, load-size encodings and writeback FSM states for the WB stage.
package mips_wb_pkg;

  localparam int MIPS_DATA_WIDTH  = 32;
  localparam int MIPS_RFIDX_WIDTH = 5;

  // Load size encodings; 2'b11 is not listed and is treated as a word load.
  localparam logic [1:0] MIPS_LDSZ_B = 2'b00;
  localparam logic [1:0] MIPS_LDSZ_H = 2'b01;
  localparam logic [1:0] MIPS_LDSZ_W = 2'b10;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mips_wb_ldfmt.sv
// Load data formatter: big-endian lane select followed by sign/zero extension.
module mips_wb_ldfmt
  import mips_wb_pkg::*;
#(
  parameter int DW = MIPS_DATA_WIDTH
) (
  input  logic [1:0]    size,
  input  logic          is_signed,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] raw,
  output logic [DW-1:0] dat
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/half (address 0 is the most significant lane) and extend it.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_lane = raw[31:24];
      2'b01:   byte_lane = raw[23:16];
      2'b10:   byte_lane = raw[15:8];
      default: byte_lane = raw[7:0];
    endcase
    // addr_lo[0] has no meaning for a halfword; only the upper/lower half is chosen.
    half_lane = addr_lo[1] ? raw[15:0] : raw[31:16];
    case (size)
      MIPS_LDSZ_B: dat = {{(DW-8){is_signed & byte_lane[7]}}, byte_lane};
      MIPS_LDSZ_H: dat = {{(DW-16){is_signed & half_lane[15]}}, half_lane};
      default:     dat = raw;
    endcase
  end

endmodule

// File: rtl/mips_wb_writeback.sv
// Writeback stage: retires MEM/WB instructions, waits for load data when needed,
// and drives a registered regfile write port with r0 writes suppressed.
module mips_wb_writeback
  import mips_wb_pkg::*;
#(
  parameter int DW = MIPS_DATA_WIDTH,
  parameter int AW = MIPS_RFIDX_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic          mem_dest_en,
  input  logic [AW-1:0] mem_dest_idx,
  input  logic [DW-1:0] mem_alu_dat,
  input  logic          mem_is_load,
  input  logic [1:0]    mem_ld_size,
  input  logic          mem_ld_signed,
  input  logic [1:0]    mem_addr_lo,
  input  logic          dmem_rsp_valid,
  input  logic [DW-1:0] dmem_rsp_dat,
  output logic          wb_dest_en,
  output logic [AW-1:0] wb_dest_idx,
  output logic [DW-1:0] wb_dest_dat
);

  wb_state_e     state_reg, state_next;

  logic          cap_dest_en_reg;
  logic [AW-1:0] cap_idx_reg;
  logic [1:0]    cap_ld_size_reg;
  logic          cap_ld_signed_reg;
  logic [1:0]    cap_addr_lo_reg;

  logic          wb_en_reg;
  logic [AW-1:0] wb_idx_reg;
  logic [DW-1:0] wb_dat_reg;

  logic          accept;
  logic          rsp_take;
  logic [DW-1:0] fmt_dat;

  assign accept   = mem_valid & mem_ready;
  assign rsp_take = (state_reg == WB_WAIT_LD) & dmem_rsp_valid;

  mips_wb_ldfmt #(.DW(DW)) u_ldfmt (
    .size      (cap_ld_size_reg),
    .is_signed (cap_ld_signed_reg),
    .addr_lo   (cap_addr_lo_reg),
    .raw       (dmem_rsp_dat),
    .dat       (fmt_dat)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= WB_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state: a load parks the stage until its response arrives.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WB_IDLE:    if (accept && mem_is_load) state_next = WB_WAIT_LD;
      WB_WAIT_LD: if (dmem_rsp_valid)        state_next = WB_IDLE;
      default:    state_next = WB_IDLE;
    endcase
  end

  // FSM outputs: back-pressure MEM for as long as a load is outstanding.
  always_comb begin
    mem_ready = (state_reg == WB_IDLE);
  end

  // Capture the retiring instruction's load-related fields on every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_dest_en_reg   <= 1'b0;
      cap_idx_reg       <= '0;
      cap_ld_size_reg   <= MIPS_LDSZ_B;
      cap_ld_signed_reg <= 1'b0;
      cap_addr_lo_reg   <= 2'b00;
    end else if (accept) begin
      cap_dest_en_reg   <= mem_dest_en;
      cap_idx_reg       <= mem_dest_idx;
      cap_ld_size_reg   <= mem_ld_size;
      cap_ld_signed_reg <= mem_ld_signed;
      cap_addr_lo_reg   <= mem_addr_lo;
    end
  end

  // Regfile write port: one-cycle enable pulse; idx/dat only move when a write issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_reg  <= 1'b0;
      wb_idx_reg <= '0;
      wb_dat_reg <= '0;
    end else begin
      wb_en_reg <= 1'b0;
      if (accept && !mem_is_load) begin
        if (mem_dest_en && (mem_dest_idx != '0)) begin
          wb_en_reg  <= 1'b1;
          wb_idx_reg <= mem_dest_idx;
          wb_dat_reg <= mem_alu_dat;
        end
      end else if (rsp_take) begin
        if (cap_dest_en_reg && (cap_idx_reg != '0)) begin
          wb_en_reg  <= 1'b1;
          wb_idx_reg <= cap_idx_reg;
          wb_dat_reg <= fmt_dat;
        end
      end
    end
  end

  assign wb_dest_en  = wb_en_reg;
  assign wb_dest_idx = wb_idx_reg;
  assign wb_dest_dat = wb_dat_reg;

endmodule
